// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared video timing types, default modes and helpers
package vga_pkg;

  // Widest axis field carried in the timing struct; CNT_W must not exceed it.
  localparam int VGA_AXIS_W = 16;
  // Width wide enough to hold the sum of four axis fields without overflow.
  localparam int VGA_SUM_W  = VGA_AXIS_W + 2;

  typedef struct packed {
    logic [VGA_AXIS_W-1:0] active;
    logic [VGA_AXIS_W-1:0] fp;
    logic [VGA_AXIS_W-1:0] sync;
    logic [VGA_AXIS_W-1:0] bp;
  } vga_axis_t;

  // 800x600@60 (40 MHz pixel clock)
  localparam vga_axis_t VGA_H_800X600 = '{active: 16'd800, fp: 16'd40, sync: 16'd128, bp: 16'd88};
  localparam vga_axis_t VGA_V_800X600 = '{active: 16'd600, fp: 16'd1,  sync: 16'd4,   bp: 16'd23};

  // 640x480@60 (25.175 MHz pixel clock)
  localparam vga_axis_t VGA_H_640X480 = '{active: 16'd640, fp: 16'd16, sync: 16'd96,  bp: 16'd48};
  localparam vga_axis_t VGA_V_640X480 = '{active: 16'd480, fp: 16'd10, sync: 16'd2,   bp: 16'd33};

  // Total number of pixels (or lines) on one axis.
  function automatic logic [VGA_SUM_W-1:0] axis_total(input vga_axis_t a);
    return VGA_SUM_W'(a.active) + VGA_SUM_W'(a.fp) + VGA_SUM_W'(a.sync) + VGA_SUM_W'(a.bp);
  endfunction

  // Replace every zero field of a runtime timing with the fallback value.
  function automatic vga_axis_t axis_merge(input vga_axis_t cfg, input vga_axis_t dflt);
    vga_axis_t r;
    r.active = (cfg.active == '0) ? dflt.active : cfg.active;
    r.fp     = (cfg.fp     == '0) ? dflt.fp     : cfg.fp;
    r.sync   = (cfg.sync   == '0) ? dflt.sync   : cfg.sync;
    r.bp     = (cfg.bp     == '0) ? dflt.bp     : cfg.bp;
    return r;
  endfunction

endpackage

// File: rtl/vga_timing_axis.sv
// rtl/vga_timing_axis.sv - one timing axis: counter, sync and blank decode
module vga_timing_axis
  import vga_pkg::*;
#(
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_i,
  input  vga_axis_t        lim_i,
  input  logic             pol_i,
  output logic [CNT_W-1:0] count_o,
  output logic             sync_o,
  output logic             blnk_o,
  output logic             wrap_o,
  output logic [CNT_W-1:0] nxt_count_o,
  output logic             nxt_blnk_o
);

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 sync_q, blnk_q;
  logic [VGA_SUM_W-1:0] sync_start, sync_stop, total, count_ext, nxt_ext;
  logic                 last, nxt_in_sync;

  // Axis boundaries are computed wide so short counters never alias.
  assign sync_start = VGA_SUM_W'(lim_i.active) + VGA_SUM_W'(lim_i.fp);
  assign sync_stop  = sync_start + VGA_SUM_W'(lim_i.sync);
  assign total      = axis_total(lim_i);
  assign count_ext  = VGA_SUM_W'(count_q);
  assign last       = (count_ext == total - VGA_SUM_W'(1));
  assign wrap_o     = step_i & last;

  // Next count: advance on step, wrap to zero after the last position.
  always_comb begin
    count_d = count_q;
    if (step_i) begin
      count_d = last ? '0 : count_q + CNT_W'(1);
    end
  end

  assign nxt_ext     = VGA_SUM_W'(count_d);
  assign nxt_in_sync = (nxt_ext >= sync_start) && (nxt_ext < sync_stop);
  assign nxt_blnk_o  = (nxt_ext >= VGA_SUM_W'(lim_i.active));
  assign nxt_count_o = count_d;

  // Counter plus registered sync/blank that always decode the registered count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      sync_q  <= ~pol_i;
      blnk_q  <= 1'b0;
    end else if (step_i) begin
      count_q <= count_d;
      sync_q  <= nxt_in_sync ? pol_i : ~pol_i;
      blnk_q  <= nxt_blnk_o;
    end
  end

  assign count_o = count_q;
  assign sync_o  = sync_q;
  assign blnk_o  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator; VGA_TIMING_CFG_EN adds runtime cfg_* timing
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 11,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
`ifdef VGA_TIMING_CFG_EN
  input  logic [CNT_W-1:0]   cfg_h_active,
  input  logic [CNT_W-1:0]   cfg_h_fp,
  input  logic [CNT_W-1:0]   cfg_h_sync,
  input  logic [CNT_W-1:0]   cfg_h_bp,
  input  logic [CNT_W-1:0]   cfg_v_active,
  input  logic [CNT_W-1:0]   cfg_v_fp,
  input  logic [CNT_W-1:0]   cfg_v_sync,
  input  logic [CNT_W-1:0]   cfg_v_bp,
`endif
  output logic [CNT_W-1:0]   hcount,
  output logic [CNT_W-1:0]   vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               de,
  output logic               sof,
  output logic               eol,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam vga_axis_t H_PARAM = '{active: VGA_AXIS_W'(H_ACTIVE), fp: VGA_AXIS_W'(H_FP),
                                    sync: VGA_AXIS_W'(H_SYNC), bp: VGA_AXIS_W'(H_BP)};
  localparam vga_axis_t V_PARAM = '{active: VGA_AXIS_W'(V_ACTIVE), fp: VGA_AXIS_W'(V_FP),
                                    sync: VGA_AXIS_W'(V_SYNC), bp: VGA_AXIS_W'(V_BP)};

  generate
    if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_err_active
      $error("vga_timing_gen: active region must be at least 1");
    end
    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_porch
      $error("vga_timing_gen: porch and sync widths must be at least 1");
    end
    if (CNT_W < 1 || CNT_W > VGA_AXIS_W) begin : g_err_width
      $error("vga_timing_gen: CNT_W out of range");
    end else if (H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_err_total
      $error("vga_timing_gen: total does not fit in CNT_W");
    end
  endgenerate

  vga_axis_t            h_lim, v_lim;
  logic                 started_q;
  logic                 de_q, sof_q, eol_q;
  logic [FRAME_W-1:0]   frame_q;
  logic                 h_step, h_wrap, v_wrap, frame_wrap;
  logic [CNT_W-1:0]     h_cnt_d, v_cnt_d;
  logic                 h_blnk_d, v_blnk_d;
  logic [VGA_SUM_W-1:0] h_last;

  assign h_step     = ce & started_q;
  assign frame_wrap = h_wrap & v_wrap;

`ifdef VGA_TIMING_CFG_EN
  vga_axis_t h_lim_q, v_lim_q, h_cfg, v_cfg;

  assign h_cfg = '{active: VGA_AXIS_W'(cfg_h_active), fp: VGA_AXIS_W'(cfg_h_fp),
                   sync: VGA_AXIS_W'(cfg_h_sync), bp: VGA_AXIS_W'(cfg_h_bp)};
  assign v_cfg = '{active: VGA_AXIS_W'(cfg_v_active), fp: VGA_AXIS_W'(cfg_v_fp),
                   sync: VGA_AXIS_W'(cfg_v_sync), bp: VGA_AXIS_W'(cfg_v_bp)};

  // Shadow timing: parameters after reset, runtime cfg latched only at frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_lim_q <= H_PARAM;
      v_lim_q <= V_PARAM;
    end else if (frame_wrap) begin
      h_lim_q <= axis_merge(h_cfg, H_PARAM);
      v_lim_q <= axis_merge(v_cfg, V_PARAM);
    end
  end

  assign h_lim = h_lim_q;
  assign v_lim = v_lim_q;
`else
  assign h_lim = H_PARAM;
  assign v_lim = V_PARAM;
`endif

  vga_timing_axis #(.CNT_W(CNT_W)) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .step_i      (h_step),
    .lim_i       (h_lim),
    .pol_i       (HS_POL),
    .count_o     (hcount),
    .sync_o      (hsync),
    .blnk_o      (hblnk),
    .wrap_o      (h_wrap),
    .nxt_count_o (h_cnt_d),
    .nxt_blnk_o  (h_blnk_d)
  );

  vga_timing_axis #(.CNT_W(CNT_W)) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .step_i      (h_wrap),
    .lim_i       (v_lim),
    .pol_i       (VS_POL),
    .count_o     (vcount),
    .sync_o      (vsync),
    .blnk_o      (vblnk),
    .wrap_o      (v_wrap),
    .nxt_count_o (v_cnt_d),
    .nxt_blnk_o  (v_blnk_d)
  );

  assign h_last = axis_total(h_lim) - VGA_SUM_W'(1);

  // Position-derived flags registered from the next position so they line up with the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      started_q <= 1'b0;
      de_q      <= 1'b0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      frame_q   <= '0;
    end else if (ce) begin
      started_q <= 1'b1;
      de_q      <= ~h_blnk_d & ~v_blnk_d;
      sof_q     <= (h_cnt_d == '0) && (v_cnt_d == '0);
      eol_q     <= (VGA_SUM_W'(h_cnt_d) == h_last);
      if (frame_wrap) begin
        frame_q <= frame_q + FRAME_W'(1);
      end
    end
  end

  assign de        = de_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b0;
  logic [10:0] cfg_h_active = '0;
  logic [10:0] cfg_zero     = '0;

  logic [10:0] h0, v0, h1, v1;
  logic hs0, vs0, hb0, vb0, de0, sof0, eol0;
  logic hs1, vs1, hb1, vb1, de1, sof1, eol1;
  logic [1:0]  fc0;
  logic [15:0] fc1;

  int checks = 0;
  int errors = 0;

  // reference position model
  bit st;
  int mh, mv, mf, ha;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CNT_W(11), .FRAME_W(2)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef VGA_TIMING_CFG_EN
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_zero), .cfg_h_sync(cfg_zero), .cfg_h_bp(cfg_zero),
    .cfg_v_active(cfg_zero), .cfg_v_fp(cfg_zero), .cfg_v_sync(cfg_zero), .cfg_v_bp(cfg_zero),
`endif
    .hcount(h0), .vcount(v0), .hsync(hs0), .vsync(vs0), .hblnk(hb0), .vblnk(vb0),
    .de(de0), .sof(sof0), .eol(eol0), .frame_cnt(fc0)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(11), .FRAME_W(16)
  ) dut_n (
    .clk(clk), .rst(rst), .ce(ce),
`ifdef VGA_TIMING_CFG_EN
    .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_zero), .cfg_h_sync(cfg_zero), .cfg_h_bp(cfg_zero),
    .cfg_v_active(cfg_zero), .cfg_v_fp(cfg_zero), .cfg_v_sync(cfg_zero), .cfg_v_bp(cfg_zero),
`endif
    .hcount(h1), .vcount(v1), .hsync(hs1), .vsync(vs1), .hblnk(hb1), .vblnk(vb1),
    .de(de1), .sof(sof1), .eol(eol1), .frame_cnt(fc1)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (h=%0d v=%0d t=%0t)", tag, got, exp, mh, mv, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      st = 0; mh = 0; mv = 0; mf = 0; ha = 8;
    end else if (ce) begin
      if (!st) begin
        st = 1;
      end else if (mh == ha + 7) begin
        mh = 0;
        if (mv == 7) begin
          mv = 0;
          mf++;
          ha = (cfg_h_active == 0) ? 8 : int'(cfg_h_active);
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
  endtask

  task automatic check_all();
    bit hs_e, vs_e;
    hs_e = (mh >= ha + 2) && (mh <= ha + 4);
    vs_e = (mv >= 5) && (mv <= 6);
    chk("hcount", h0, mh);
    chk("vcount", v0, mv);
    chk("hsync", hs0, hs_e);
    chk("vsync", vs0, vs_e);
    chk("hblnk", hb0, mh >= ha);
    chk("vblnk", vb0, mv >= 4);
    chk("de", de0, st && (mh < ha) && (mv < 4));
    chk("sof", sof0, st && (mh == 0) && (mv == 0));
    chk("eol", eol0, mh == ha + 7);
    chk("frame_cnt", fc0, mf % 4);
    chk("hcount_n", h1, mh);
    chk("hsync_n", hs1, !hs_e);
    chk("vsync_n", vs1, !vs_e);
    chk("de_n", de1, st && (mh < ha) && (mv < 4));
    chk("frame_cnt_w", fc1, mf % 65536);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  int sof_seen;
  int last_sof;
  int fseq [5] = '{1, 2, 3, 0, 1};
  int n;

  initial begin
    st = 0; mh = 0; mv = 0; mf = 0; ha = 8;
    sof_seen = 0;
    last_sof = -1;

    // reset state
    rst = 1'b1; ce = 1'b0;
    tick();
    tick();
    chk("rst_hsync", hs0, 0);
    chk("rst_hsync_n", hs1, 1);
    chk("rst_vsync_n", vs1, 1);
    chk("rst_de", de0, 0);
    chk("rst_sof", sof0, 0);

    // ce toggling after reset: start, hold, advance, hold, advance, hold
    rst = 1'b0;
    ce = 1'b1; tick();
    chk("start_sof", sof0, 1);
    chk("start_de", de0, 1);
    chk("start_h", h0, 0);
    ce = 1'b0; tick();
    chk("hold_sof", sof0, 1);
    chk("hold_h", h0, 0);
    ce = 1'b1; tick();
    chk("adv_sof", sof0, 0);
    chk("adv_h", h0, 1);
    ce = 1'b0; tick();
    chk("hold2_h", h0, 1);
    ce = 1'b1; tick();
    ce = 1'b0; tick();
    chk("hold3_h", h0, 2);

    // five frames at full rate
    chk("frame0", fc0, 0);
    ce = 1'b1;
    for (int i = 0; i < 640; i++) begin
      tick();
      if (sof0) begin
        if (last_sof >= 0) chk("sof_period", i - last_sof, 128);
        if (sof_seen < 5) chk("frame_seq", fc0, fseq[sof_seen]);
        last_sof = i;
        sof_seen++;
      end
      if (h0 == 11'd15) chk("eol_at_15", eol0, 1);
      if (h0 == 11'd10 && v0 == 11'd5) chk("hv_sync_corner", {hs0, vs0}, 3);
    end
    chk("sof_count", sof_seen, 5);

    // reset mid-frame at (5,3), ce low during reset
    n = 0;
    while (!(h0 == 11'd5 && v0 == 11'd3) && n < 300) begin
      tick();
      n++;
    end
    chk("reach_5_3", (h0 == 11'd5 && v0 == 11'd3), 1);
    rst = 1'b1; ce = 1'b0;
    tick();
    chk("mid_rst_h", h0, 0);
    chk("mid_rst_v", v0, 0);
    chk("mid_rst_frame", fc0, 0);
    chk("mid_rst_de", de0, 0);
    chk("mid_rst_hsync_n", hs1, 1);
    rst = 1'b0; ce = 1'b1;
    tick();
    chk("restart_sof", sof0, 1);
    chk("restart_de", de0, 1);
    for (int i = 0; i < 20; i++) tick();

`ifdef VGA_TIMING_CFG_EN
    // runtime active width change becomes visible only at the next frame
    n = 0;
    while (!(h0 == 11'd3 && v0 == 11'd2) && n < 300) begin
      tick();
      n++;
    end
    cfg_h_active = 11'd6;
    n = 0;
    while (!sof0 && n < 300) begin
      tick();
      if (eol0) chk("cfg_old_eol", h0, 15);
      n++;
    end
    chk("cfg_sof_seen", sof0, 1);
    n = 0;
    while (!eol0 && n < 40) begin
      tick();
      if (h0 == 11'd6) chk("cfg_hblnk_6", hb0, 1);
      if (h0 == 11'd5) chk("cfg_hblnk_5", hb0, 0);
      n++;
    end
    chk("cfg_new_eol", h0, 13);
    for (int i = 0; i < 30; i++) tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
